main_control_fsm: RTL

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm_if.sv | 43 ++++
 rtl/main_control_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - instruction/memory handshake and control outputs of main_control_fsm
// The mem_err member exists only when MEM_TIMEOUT_EN is defined.
interface main_control_fsm_if;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       instr_ready;
    logic [1:0] ALUOp;
    logic [5:0] Function;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       done;
    logic       illegal_op;
`ifdef MEM_TIMEOUT_EN
    logic       mem_err;

    modport master (
        output instr_valid, opcode, funct, mem_ready,
        input  instr_ready, ALUOp, Function, RegWrite, MemRead, MemWrite,
               Branch, Jump, done, illegal_op, mem_err
    );
    modport slave (
        input  instr_valid, opcode, funct, mem_ready,
        output instr_ready, ALUOp, Function, RegWrite, MemRead, MemWrite,
               Branch, Jump, done, illegal_op, mem_err
    );
`else
    modport master (
        output instr_valid, opcode, funct, mem_ready,
        input  instr_ready, ALUOp, Function, RegWrite, MemRead, MemWrite,
               Branch, Jump, done, illegal_op
    );
    modport slave (
        input  instr_valid, opcode, funct, mem_ready,
        output instr_ready, ALUOp, Function, RegWrite, MemRead, MemWrite,
               Branch, Jump, done, illegal_op
    );
`endif
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - 5-state multicycle main control FSM (IDLE/DECODE/EXEC/MEM/WB)
// Optional MEM-state timeout with sticky mem_err when MEM_TIMEOUT_EN is defined.
module main_control_fsm (
    input logic              clk,
    input logic              reset,
    main_control_fsm_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [2:0] K_R   = 3'd0;
    localparam logic [2:0] K_LW  = 3'd1;
    localparam logic [2:0] K_SW  = 3'd2;
    localparam logic [2:0] K_BNE = 3'd3;
    localparam logic [2:0] K_J   = 3'd4;
    localparam logic [2:0] K_ILL = 3'd5;

    logic [2:0] state;
    logic [2:0] kind;
    logic [1:0] alu_op;
    logic [5:0] func_q;
    logic [2:0] new_kind;
    logic [1:0] new_alu_op;
    logic       timeout_hit;

    // Classify the incoming opcode; only sampled on acceptance in IDLE.
    always_comb begin
        new_kind   = K_ILL;
        new_alu_op = 2'b00;
        case (bus.opcode)
            6'b000000: begin new_kind = K_R;   new_alu_op = 2'b10; end
            6'b100011: begin new_kind = K_LW;  new_alu_op = 2'b01; end
            6'b101011: begin new_kind = K_SW;  new_alu_op = 2'b01; end
            6'b000101: begin new_kind = K_BNE; new_alu_op = 2'b11; end
            6'b000010: begin new_kind = K_J;   new_alu_op = 2'b00; end
            default:   begin new_kind = K_ILL; new_alu_op = 2'b00; end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       mem_err_q;

    // The 16th consecutive not-ready MEM cycle is the one seen with wait_cnt at 15.
    assign timeout_hit = (state == S_MEM) && !bus.mem_ready && (wait_cnt == 4'hF);
    assign bus.mem_err = mem_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            mem_err_q <= 1'b0;
        end else if (state == S_EXEC) begin
            wait_cnt <= 4'd0;
        end else if (state == S_MEM && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == 4'hF) begin
                mem_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            kind   <= K_ILL;
            alu_op <= 2'b00;
            func_q <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        state  <= S_DECODE;
                        kind   <= new_kind;
                        alu_op <= new_alu_op;
                        func_q <= bus.funct;
                    end
                end
                S_DECODE: begin
                    state <= (kind == K_ILL) ? S_IDLE : S_EXEC;
                end
                S_EXEC: begin
                    case (kind)
                        K_R:        state <= S_WB;
                        K_LW, K_SW: state <= S_MEM;
                        default:    state <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        state <= (kind == K_LW) ? S_WB : S_IDLE;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by reset so an abandoned instruction never leaks a done pulse.
    logic in_mem_access;
    assign in_mem_access = (state == S_MEM) && !timeout_hit && !reset;

    assign bus.instr_ready = (state == S_IDLE) && !reset;
    assign bus.ALUOp       = alu_op;
    assign bus.Function    = func_q;
    assign bus.RegWrite    = (state == S_WB) && !reset;
    assign bus.MemRead     = in_mem_access && (kind == K_LW);
    assign bus.MemWrite    = in_mem_access && (kind == K_SW);
    assign bus.Branch      = (state == S_EXEC) && (kind == K_BNE) && !reset;
    assign bus.Jump        = (state == S_EXEC) && (kind == K_J) && !reset;
    assign bus.illegal_op  = (state == S_DECODE) && (kind == K_ILL) && !reset;
    assign bus.done        = !reset && ((state == S_WB)
                           || ((state == S_MEM) && (kind == K_SW) && bus.mem_ready)
                           || ((state == S_EXEC) && ((kind == K_BNE) || (kind == K_J))));
endmodule
